// File: rtl/hazard_scoreboard_unit.sv
// ============================================================================
// Module      : hazard_scoreboard_unit
// Description : Control, load-use and long-operation hazard controller for
//               the 5-stage core. Defining HAZARD_SCOREBOARD_EN builds the
//               register scoreboard for variable-latency operations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard_unit #(
    parameter int REG_IDX_W         = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MAX_OUTSTANDING   = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [REG_IDX_W-1:0]                     id_reg1_idx,
    input  logic [REG_IDX_W-1:0]                     id_reg2_idx,
    input  logic                                     id_long_op_en,
    input  logic                                     pc_jump_enable,
    input  logic [REG_IDX_W-1:0]                     ex_reg_wr_idx,
    input  logic                                     ex_do_mem_read_en,
    input  logic                                     ex_long_op_en,
    input  logic                                     wb_long_done_en,
    input  logic [REG_IDX_W-1:0]                     wb_long_done_idx,
    output logic                                     hazard_fe_enable,
    output logic                                     hazard_if_id_clear,
    output logic                                     hazard_id_ex_clear,
    output logic                                     hazard_stall_active,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     hazard_outstanding_cnt
);

    localparam int          c_cnt_w    = $clog2(MAX_OUTSTANDING + 1);
    localparam int          c_num_regs = 1 << REG_IDX_W;
    localparam logic [2:0]  c_stall_ld = 3'(LOAD_STALL_CYCLES - 1);

    logic [2:0] r_stall_cnt;
    logic       w_load_use;
    logic       w_sb_hit;
    logic       w_sb_full;
    logic       w_stall;

    assign w_load_use = ex_do_mem_read_en
                     && (ex_reg_wr_idx != '0)
                     && ((ex_reg_wr_idx == id_reg1_idx) || (ex_reg_wr_idx == id_reg2_idx));

    assign w_stall = w_load_use || w_sb_hit || w_sb_full || (r_stall_cnt != 3'd0);

`ifdef HAZARD_SCOREBOARD_EN
    localparam logic [c_cnt_w-1:0] c_max_out = c_cnt_w'(MAX_OUTSTANDING);

    logic [c_num_regs-1:0] r_pending;
    logic [c_cnt_w-1:0]    r_out_cnt;
    logic                  w_sb_set;
    logic                  w_sb_clr;

    // x0 is never marked, so a completion to x0 can never clear anything.
    assign w_sb_set  = ex_long_op_en && (ex_reg_wr_idx != '0);
    assign w_sb_clr  = wb_long_done_en && r_pending[wb_long_done_idx];
    assign w_sb_hit  = r_pending[id_reg1_idx] || r_pending[id_reg2_idx];
    assign w_sb_full = id_long_op_en && (r_out_cnt == c_max_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_out_cnt <= '0;
        end else begin
            // Set is applied last so a same-index set+clear leaves the bit set.
            if (w_sb_clr) r_pending[wb_long_done_idx] <= 1'b0;
            if (w_sb_set) r_pending[ex_reg_wr_idx]    <= 1'b1;
            case ({w_sb_set, w_sb_clr})
                2'b10:   r_out_cnt <= r_out_cnt + c_cnt_w'(1);
                2'b01:   r_out_cnt <= r_out_cnt - c_cnt_w'(1);
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    assign hazard_outstanding_cnt = r_out_cnt;
`else
    logic w_unused_sb;

    assign w_sb_hit               = 1'b0;
    assign w_sb_full              = 1'b0;
    assign hazard_outstanding_cnt = '0;
    assign w_unused_sb            = ^{id_long_op_en, ex_long_op_en, wb_long_done_en, wb_long_done_idx};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 3'd0;
        end else if (pc_jump_enable) begin
            // The stalled ID instruction is wrong-path once a jump resolves.
            r_stall_cnt <= 3'd0;
        end else if (r_stall_cnt != 3'd0) begin
            r_stall_cnt <= r_stall_cnt - 3'd1;
        end else if (w_load_use) begin
            r_stall_cnt <= c_stall_ld;
        end
    end

    assign hazard_stall_active = (r_stall_cnt != 3'd0);

    always_comb begin
        hazard_fe_enable   = 1'b1;
        hazard_if_id_clear = 1'b0;
        hazard_id_ex_clear = 1'b0;
        if (pc_jump_enable) begin
            hazard_if_id_clear = 1'b1;
            hazard_id_ex_clear = 1'b1;
        end else if (w_stall) begin
            hazard_fe_enable   = 1'b0;
            hazard_id_ex_clear = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
// ============================================================================
// Module      : tb_hazard_scoreboard_unit
// Description : Directed self-checking bench for hazard_scoreboard_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_reg1_idx, id_reg2_idx, ex_reg_wr_idx, wb_long_done_idx;
    logic       id_long_op_en, pc_jump_enable, ex_do_mem_read_en;
    logic       ex_long_op_en, wb_long_done_en;

    logic       fe, ifclr, idclr, stall_act;
    logic [1:0] out_cnt;
    logic       fe1, ifclr1, idclr1, stall_act1;
    logic [2:0] out_cnt1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.REG_IDX_W(5), .LOAD_STALL_CYCLES(3), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .id_reg1_idx(id_reg1_idx), .id_reg2_idx(id_reg2_idx), .id_long_op_en(id_long_op_en),
        .pc_jump_enable(pc_jump_enable), .ex_reg_wr_idx(ex_reg_wr_idx),
        .ex_do_mem_read_en(ex_do_mem_read_en), .ex_long_op_en(ex_long_op_en),
        .wb_long_done_en(wb_long_done_en), .wb_long_done_idx(wb_long_done_idx),
        .hazard_fe_enable(fe), .hazard_if_id_clear(ifclr), .hazard_id_ex_clear(idclr),
        .hazard_stall_active(stall_act), .hazard_outstanding_cnt(out_cnt)
    );

    // Default-parameter instance: single-bubble load-use behaviour.
    hazard_scoreboard_unit dut1 (
        .clk(clk), .rst(rst),
        .id_reg1_idx(id_reg1_idx), .id_reg2_idx(id_reg2_idx), .id_long_op_en(id_long_op_en),
        .pc_jump_enable(pc_jump_enable), .ex_reg_wr_idx(ex_reg_wr_idx),
        .ex_do_mem_read_en(ex_do_mem_read_en), .ex_long_op_en(ex_long_op_en),
        .wb_long_done_en(wb_long_done_en), .wb_long_done_idx(wb_long_done_idx),
        .hazard_fe_enable(fe1), .hazard_if_id_clear(ifclr1), .hazard_id_ex_clear(idclr1),
        .hazard_stall_active(stall_act1), .hazard_outstanding_cnt(out_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_reg1_idx = 5'd1; id_reg2_idx = 5'd2; id_long_op_en = 1'b0;
        pc_jump_enable = 1'b0; ex_reg_wr_idx = 5'd3; ex_do_mem_read_en = 1'b0;
        ex_long_op_en = 1'b0; wb_long_done_en = 1'b0; wb_long_done_idx = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {fe, if_id_clear, id_ex_clear} of the main instance.
    task automatic chk_ctl(input string tag, input logic [2:0] exp);
        #1;
        chk(tag, {29'd0, fe, ifclr, idclr}, {29'd0, exp});
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        chk("reset_stall_active", {31'd0, stall_act}, 32'd0);
        chk("reset_out_cnt", {30'd0, out_cnt}, 32'd0);
        chk_ctl("reset_ctl", 3'b100);
        rst = 1'b0;
        tick();

        // Idle pipeline, no hazards.
        for (int i = 0; i < 3; i++) begin
            chk_ctl("idle_ctl", 3'b100);
            tick();
        end

        // Load-use: 3 bubbles on main instance, 1 on default instance.
        ex_do_mem_read_en = 1'b1; ex_reg_wr_idx = 5'd5; id_reg1_idx = 5'd5;
        chk_ctl("lu_c1_ctl", 3'b001);
        chk("lu_c1_active", {31'd0, stall_act}, 32'd0);
        chk("lu1_c1_fe", {31'd0, fe1}, 32'd0);
        tick();
        ex_do_mem_read_en = 1'b0; ex_reg_wr_idx = 5'd0;
        chk_ctl("lu_c2_ctl", 3'b001);
        chk("lu_c2_active", {31'd0, stall_act}, 32'd1);
        chk("lu1_c2_fe", {31'd0, fe1}, 32'd1);
        chk("lu1_c2_active", {31'd0, stall_act1}, 32'd0);
        tick();
        chk_ctl("lu_c3_ctl", 3'b001);
        chk("lu_c3_active", {31'd0, stall_act}, 32'd1);
        tick();
        chk_ctl("lu_c4_ctl", 3'b100);
        chk("lu_c4_active", {31'd0, stall_act}, 32'd0);
        tick();

        // Load-use interrupted by a jump in stall cycle 2.
        ex_do_mem_read_en = 1'b1; ex_reg_wr_idx = 5'd5; id_reg2_idx = 5'd5;
        chk_ctl("lj_c1_ctl", 3'b001);
        tick();
        ex_do_mem_read_en = 1'b0; ex_reg_wr_idx = 5'd0; pc_jump_enable = 1'b1;
        chk_ctl("lj_c2_ctl", 3'b111);
        tick();
        pc_jump_enable = 1'b0;
        chk_ctl("lj_c3_ctl", 3'b100);
        chk("lj_c3_active", {31'd0, stall_act}, 32'd0);
        idle();
        tick();

`ifdef HAZARD_SCOREBOARD_EN
        // Long op to x7; consumer waits until completion is sampled.
        ex_long_op_en = 1'b1; ex_reg_wr_idx = 5'd7;
        tick();
        ex_long_op_en = 1'b0; ex_reg_wr_idx = 5'd0; id_reg2_idx = 5'd7;
        wb_long_done_en = 1'b1; wb_long_done_idx = 5'd9;
        chk("sb_issue_cnt", {30'd0, out_cnt}, 32'd1);
        chk_ctl("sb_hit_ctl", 3'b001);
        tick();
        wb_long_done_idx = 5'd7;
        chk("sb_x9_cnt", {30'd0, out_cnt}, 32'd1);
        chk_ctl("sb_done_cycle_ctl", 3'b001);
        tick();
        wb_long_done_en = 1'b0;
        chk("sb_done_cnt", {30'd0, out_cnt}, 32'd0);
        chk_ctl("sb_release_ctl", 3'b100);
        idle();

        // Fill to MAX_OUTSTANDING=2, then a long op in ID must wait.
        ex_long_op_en = 1'b1; ex_reg_wr_idx = 5'd10;
        tick();
        ex_reg_wr_idx = 5'd11;
        tick();
        ex_long_op_en = 1'b0; ex_reg_wr_idx = 5'd3; id_long_op_en = 1'b1;
        chk("full_cnt", {30'd0, out_cnt}, 32'd2);
        chk_ctl("full_ctl", 3'b001);
        wb_long_done_en = 1'b1; wb_long_done_idx = 5'd10;
        tick();
        wb_long_done_en = 1'b0;
        chk("full_done_cnt", {30'd0, out_cnt}, 32'd1);
        chk_ctl("full_release_ctl", 3'b100);
        id_long_op_en = 1'b0;

        // Same-cycle set and clear of x4.
        ex_long_op_en = 1'b1; ex_reg_wr_idx = 5'd4;
        tick();
        ex_long_op_en = 1'b0;
        wb_long_done_en = 1'b1; wb_long_done_idx = 5'd11;
        tick();
        ex_long_op_en = 1'b1; ex_reg_wr_idx = 5'd4; wb_long_done_idx = 5'd4;
        tick();
        ex_long_op_en = 1'b0; ex_reg_wr_idx = 5'd3; wb_long_done_en = 1'b0;
        id_reg1_idx = 5'd4;
        chk("setclr_cnt", {30'd0, out_cnt}, 32'd1);
        chk_ctl("setclr_pending_ctl", 3'b001);
`else
        // Without the scoreboard, long-op inputs are ignored.
        ex_long_op_en = 1'b1; ex_reg_wr_idx = 5'd7;
        tick();
        ex_long_op_en = 1'b0; ex_reg_wr_idx = 5'd3; id_reg2_idx = 5'd7; id_long_op_en = 1'b1;
        chk("nosb_cnt", {30'd0, out_cnt}, 32'd0);
        chk_ctl("nosb_ctl", 3'b100);
        idle();
`endif

        // Reset mid-stall with a long op in flight.
        ex_do_mem_read_en = 1'b1; ex_reg_wr_idx = 5'd12; id_reg1_idx = 5'd12;
        ex_long_op_en = 1'b1;
        tick();
        idle();
        id_reg1_idx = 5'd4;
        chk("prerst_active", {31'd0, stall_act}, 32'd1);
`ifdef HAZARD_SCOREBOARD_EN
        chk("prerst_cnt", {30'd0, out_cnt}, 32'd2);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("postrst_active", {31'd0, stall_act}, 32'd0);
        chk("postrst_cnt", {30'd0, out_cnt}, 32'd0);
        chk_ctl("postrst_ctl", 3'b100);
        tick();

        // Long op to x0 never marks a register.
        ex_long_op_en = 1'b1; ex_reg_wr_idx = 5'd0;
        tick();
        ex_long_op_en = 1'b0; ex_reg_wr_idx = 5'd3; id_reg1_idx = 5'd0;
        chk("x0_cnt", {30'd0, out_cnt}, 32'd0);
        chk_ctl("x0_ctl", 3'b100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
